serial_uncomplement: RTL and testbench

Bit-serial complement decoder: receives a W-bit word LSB-first on a single data line, removes its one's- or two's-complement encoding on the fly, and presents the recovered parallel word with a one-cycle valid strobe. It is the receive end of the complement path: upstream logic complements a parallel word and shifts it out serially, and this block restores the original value for the rest of the lab datapath.

---
 rtl/serial_uncomplement.sv | 107 ++++++++++
 tb/tb_serial_uncomplement.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_uncomplement.sv
// Purpose: bit-serial complement decoder; restores a W-bit word sent LSB-first in one's or two's complement form.
// Latency: recovered word appears on O with a one-cycle valid pulse W-1 cycles after the start edge.
// Backpressure: none; a start seen while a word is in progress is flagged on err and otherwise ignored.
module serial_uncomplement #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         din,
    input  logic         mode,
    output logic [W-1:0] O,
    output logic         valid,
    output logic         busy,
    output logic         err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [W-1:0]    sr, sr_nxt;
    logic            seen_one, seen_one_nxt;
    logic            mode_r, mode_r_nxt;
    logic [W-1:0]    o_nxt;
    logic            valid_nxt;
    logic            err_nxt;
    logic            out_bit;

    // Register all state; synchronous reset wins over everything and discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            seen_one <= 1'b0;
            mode_r   <= 1'b0;
            O        <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sr       <= sr_nxt;
            seen_one <= seen_one_nxt;
            mode_r   <= mode_r_nxt;
            O        <= o_nxt;
            valid    <= valid_nxt;
            err      <= err_nxt;
        end
    end

    // Next-state and per-bit decode: one's complement inverts every bit, two's complement
    // copies bits up to and including the first one and inverts the rest.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sr_nxt       = sr;
        seen_one_nxt = seen_one;
        mode_r_nxt   = mode_r;
        o_nxt        = O;
        valid_nxt    = 1'b0;
        err_nxt      = 1'b0;
        out_bit      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    // First bit of a word: seen_one is implicitly clear here.
                    out_bit      = mode ? din : ~din;
                    seen_one_nxt = din;
                    mode_r_nxt   = mode;
                    sr_nxt       = {out_bit, sr[W-1:1]};
                    cnt_nxt      = CW'(1);
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                err_nxt      = start;
                out_bit      = (mode_r && !seen_one) ? din : ~din;
                seen_one_nxt = seen_one | din;
                sr_nxt       = {out_bit, sr[W-1:1]};
                if (cnt == LAST_BIT) begin
                    // Final bit lands in the MSB; older bits have shifted down into place.
                    o_nxt     = {out_bit, sr[W-1:1]};
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_uncomplement.sv
// Purpose: directed self-checking bench for serial_uncomplement.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: not applicable.
module tb_serial_uncomplement;

    logic       clk;
    logic       rst;
    logic       start;
    logic       din;
    logic       mode;
    logic [7:0] O;
    logic       valid;
    logic       busy;
    logic       err;

    int errors;
    int checks;

    serial_uncomplement #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .mode  (mode),
        .O     (O),
        .valid (valid),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; din = 1'b0; mode = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({O, valid, busy, err} !== 11'h000) begin
            errors++;
            $display("FAIL reset_state: O=%h valid=%b busy=%b err=%b, required 00/0/0/0", O, valid, busy, err);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({O, valid, busy, err} !== 11'h000) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: O=%h valid=%b busy=%b err=%b, required 00/0/0/0", i, O, valid, busy, err);
            end
        end
    endtask

    task automatic test_ones_complement();
        logic [7:0] w;
        int busy_cnt;
        w = 8'h0F;
        busy_cnt = 0;
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            din   = w[i];
            step();
            start = 1'b0;
            if (busy) busy_cnt++;
            if (i < 7) begin
                checks++;
                if (valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ones_inflight bit %0d: valid=%b busy=%b, required 0/1", i, valid, busy);
                end
            end
        end
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || O !== 8'hF0) begin
            errors++;
            $display("FAIL ones_done: valid=%b busy=%b O=%h, required 1/0/f0", valid, busy, O);
        end
        step();
        checks++;
        if (valid !== 1'b0 || O !== 8'hF0) begin
            errors++;
            $display("FAIL ones_hold: valid=%b O=%h, required 0/f0", valid, O);
        end
        checks++;
        if (busy_cnt !== 7) begin
            errors++;
            $display("FAIL ones_busy_len: got %0d cycles, required 7", busy_cnt);
        end
    endtask

    task automatic test_twos_complement();
        logic [7:0] ins [4];
        logic [7:0] exps [4];
        logic [7:0] w;
        ins  = '{8'hDE, 8'h00, 8'h80, 8'hFF};
        exps = '{8'h22, 8'h00, 8'h80, 8'h01};
        for (int k = 0; k < 4; k++) begin
            w = ins[k];
            for (int i = 0; i < 8; i++) begin
                start = (i == 0);
                mode  = (i == 0) ? 1'b1 : 1'b0;
                din   = w[i];
                step();
                start = 1'b0;
            end
            checks++;
            if (valid !== 1'b1 || O !== exps[k]) begin
                errors++;
                $display("FAIL twos_%h: valid=%b O=%h, required 1/%h", ins[k], valid, O, exps[k]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        int v_first, v_second, v_count, e_count;
        a = 8'hAA; b = 8'hDE;
        v_first = -1; v_second = -1; v_count = 0; e_count = 0;
        for (int i = 0; i < 18; i++) begin
            start = (i == 0) || (i == 8);
            if (i == 0)  mode = 1'b0;
            if (i == 3)  mode = 1'b1;
            if (i == 8)  mode = 1'b1;
            if (i == 11) mode = 1'b0;
            din = (i < 8) ? a[i] : ((i < 16) ? b[i-8] : 1'b0);
            step();
            start = 1'b0;
            if (err) e_count++;
            if (valid) begin
                v_count++;
                if (v_first < 0) begin
                    v_first = i;
                    checks++;
                    if (O !== 8'h55) begin
                        errors++;
                        $display("FAIL b2b_first: O=%h, required 55", O);
                    end
                end else begin
                    v_second = i;
                    checks++;
                    if (O !== 8'h22) begin
                        errors++;
                        $display("FAIL b2b_second: O=%h, required 22", O);
                    end
                end
            end
        end
        checks++;
        if (v_count !== 2 || v_first !== 7 || (v_second - v_first) !== 8) begin
            errors++;
            $display("FAIL b2b_timing: pulses=%0d first=%0d second=%0d, required 2/7/15", v_count, v_first, v_second);
        end
        checks++;
        if (e_count !== 0) begin
            errors++;
            $display("FAIL b2b_no_err: err pulses=%0d, required 0", e_count);
        end
    endtask

    task automatic test_err();
        logic [7:0] w;
        int v_count, e_count;
        w = 8'h0F; v_count = 0; e_count = 0;
        mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 0) || (i == 3);
            din   = (i < 8) ? w[i] : 1'b0;
            step();
            start = 1'b0;
            if (valid) v_count++;
            if (err) e_count++;
            if (i == 3) begin
                checks++;
                if (err !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL err_pulse: err=%b busy=%b, required 1/1", err, busy);
                end
            end
            if (i == 7) begin
                checks++;
                if (valid !== 1'b1 || O !== 8'hF0) begin
                    errors++;
                    $display("FAIL err_word: valid=%b O=%h, required 1/f0", valid, O);
                end
            end
        end
        checks++;
        if (v_count !== 1 || e_count !== 1) begin
            errors++;
            $display("FAIL err_counts: valid pulses=%0d err pulses=%0d, required 1/1", v_count, e_count);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'h0F;
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            din   = w[i];
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        din = w[4];
        step();
        rst = 1'b0;
        checks++;
        if (O !== 8'h00 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: O=%h busy=%b valid=%b, required 00/0/0", O, busy, valid);
        end
        w = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            din   = w[i];
            step();
            start = 1'b0;
        end
        checks++;
        if (valid !== 1'b1 || O !== 8'h0F) begin
            errors++;
            $display("FAIL rst_fresh_word: valid=%b O=%h, required 1/0f", valid, O);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ones_complement();
        test_twos_complement();
        test_back_to_back();
        test_err();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
